mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit for the processor core. It is the sequential counterpart of the single-cycle ALU: it takes the same rs1/rs2 operand pair, selects the operation by funct3, and returns a 32-bit result after a fixed multi-cycle latency. A start/busy/done handshake lets the controller stall writeback until done.

---
 rtl/mul_div_if.sv | 12 +
 rtl/mul_div_unit.sv | 89 ++++++++
 tb/tb_mul_div_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// mul_div_if: request/response bundle between the core controller and the multiply/divide unit
interface mul_div_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      md_op;
    logic [XLEN-1:0] a_in;
    logic [XLEN-1:0] b_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, md_op, a_in, b_in, input busy, done, result);
    modport slave (input start, md_op, a_in, b_in, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit with a fixed 32-iteration latency
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic     clk,
    input logic     rst_n,
    mul_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rmd, fin_val;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] step, prod;
    // Accept on magnitudes, iterate shift-add or restoring divide, apply signs on the last iteration
    always_comb begin
        a_sgn    = bus.a_in[XLEN-1] & (bus.md_op inside {3'd1, 3'd2, 3'd4, 3'd6});
        b_sgn    = bus.b_in[XLEN-1] & (bus.md_op inside {3'd1, 3'd4, 3'd6});
        a_mag    = a_sgn ? -bus.a_in : bus.a_in;
        b_mag    = b_sgn ? -bus.b_in : bus.b_in;
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, opnd_q};
        step     = !op_q[2] ? {mul_sum, acc_q[XLEN-1:1]} :
                   diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                   {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod     = neg_q ? -step : step;
        quo      = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rmd      = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        fin_val  = op_q == 3'd0 ? prod[XLEN-1:0] :
                   !op_q[2] ? prod[2*XLEN-1:XLEN] :
                   op_q[1] ? rmd : quo;
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (bus.start && state_q != CALC) begin
            state_d = CALC;
            cnt_d   = CNT_W'(XLEN);
            op_d    = bus.md_op;
            opnd_d  = bus.md_op[2] ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, bus.md_op[2] ? a_mag : b_mag};
            neg_d   = bus.md_op[2:1] == 2'b11 ? a_sgn :
                      bus.md_op[2] && bus.b_in == '0 ? 1'b0 : a_sgn ^ b_sgn;
        end else if (state_q == CALC) begin
            acc_d = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d  = FIN;
                result_d = fin_val;
            end
        end else if (state_q == FIN) begin
            state_d = IDLE;
        end
    end
    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end
    assign bus.busy   = state_q == CALC;
    assign bus.done   = state_q == FIN;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against an arithmetic reference
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    mul_div_if #(.XLEN(32)) bus_if ();
    mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.start = 1'b1;
        bus_if.md_op = op;
        bus_if.a_in  = a;
        bus_if.b_in  = b;
    endtask

    // Accept edge, then count edges until done while disturbing the inputs mid-operation
    task automatic wait_done(input string tag, input logic [31:0] exp, input bit hold);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.md_op = 3'($urandom);
        bus_if.a_in  = $urandom;
        bus_if.b_in  = $urandom;
        chk({tag, "_busy_after_accept"}, {31'b0, bus_if.busy}, 32'd1);
        while (!bus_if.done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) bus_if.start = 1'b1;
            if (n == 6) bus_if.start = 1'b0;
            if (!bus_if.done && n < 32) chk({tag, "_busy_calc"}, {31'b0, bus_if.busy}, 32'd1);
        end
        chk({tag, "_latency"}, n, 32);
        chk({tag, "_result"}, bus_if.result, exp);
        chk({tag, "_busy_fin"}, {31'b0, bus_if.busy}, 32'd0);
        if (hold) begin
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, {31'b0, bus_if.done}, 32'd0);
            chk({tag, "_idle_busy"}, {31'b0, bus_if.busy}, 32'd0);
            chk({tag, "_hold"}, bus_if.result, exp);
        end
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bit          saw_done;
        bus_if.start = 1'b0;
        bus_if.md_op = 3'd0;
        bus_if.a_in  = '0;
        bus_if.b_in  = '0;
        #1;
        chk("reset_busy", {31'b0, bus_if.busy}, 32'd0);
        chk("reset_done", {31'b0, bus_if.done}, 32'd0);
        chk("reset_result", bus_if.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", {31'b0, bus_if.busy}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_done($sformatf("dir%0d_op%0d", i, d_op[i]), d_exp[i], 1'b1);
        end
        issue(3'd0, 32'd12345, 32'd678);
        wait_done("b2b_first", 32'd8369910, 1'b0);
        issue(3'd5, 32'd1000, 32'd33);
        wait_done("b2b_second", 32'd30, 1'b1);
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = (i % 6 == 0) ? 32'd0 : (i % 5 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            issue(op, a, b);
            wait_done($sformatf("rnd%0d_op%0d", i, op), ref_md(op, a, b), i[0]);
        end
        issue(3'd0, 32'd5, 32'd6);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bus_if.busy}, 32'd0);
        chk("abort_done", {31'b0, bus_if.done}, 32'd0);
        chk("abort_result", bus_if.result, 32'd0);
        saw_done = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            saw_done |= bus_if.done;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            saw_done |= bus_if.done;
        end
        chk("abort_no_done", {31'b0, saw_done}, 32'd0);
        chk("abort_idle_result", bus_if.result, 32'd0);
        issue(3'd6, 32'hFFFF_FF9C, 32'd7);
        wait_done("after_reset_rem", 32'hFFFF_FFFE, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
